// File: rtl/reset_sequencer.sv
// Ordered reset-release controller with a four-phase soft-reset handshake.
// After rst_n (or an accepted soft request) every domain reset is asserted,
// then the domains are released one at a time, lowest index first. Before
// each release the sequencer waits a fixed gap of GAP_CYCLES clocks.
module reset_sequencer #(
   parameter int unsigned CLOCK_HZ     = 48000000,
   parameter int unsigned STAGE_GAP_NS = 1000000,
   parameter int unsigned STAGES       = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              soft_req,
   output logic              soft_ack,
   output logic [STAGES-1:0] stage_rst,
   output logic              all_ready,
   output logic              busy
);

   // A 64-bit product keeps large CLOCK_HZ * STAGE_GAP_NS values from overflowing.
   localparam longint unsigned GAP_L =
      (longint'(STAGE_GAP_NS) * longint'(CLOCK_HZ)) / 64'd1000000000;
   localparam int unsigned GAP_CYCLES = int'(GAP_L);
   localparam int          CNT_W      = $clog2(GAP_CYCLES + 1);
   localparam int          IDX_W      = $clog2(STAGES + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(STAGES - 1);

   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("reset_sequencer: GAP_CYCLES must be >= 1");
   end
   if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
      $error("reset_sequencer: STAGES must be in 1..16");
   end

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_RELEASE,
      ST_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [STAGES-1:0] stage_rst_q, stage_rst_d;
   logic              soft_run_q, soft_run_d;   // current sequence was started by soft_req
   logic              soft_ack_q, soft_ack_d;
   logic              busy_q, all_ready_q;

   // Next-state logic: gap countdown, in-order release, soft-request handshake.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      stage_rst_d = stage_rst_q;
      soft_run_d  = soft_run_q;
      soft_ack_d  = soft_ack_q;

      unique case (state_q)
         ST_ASSERT: begin
            if (cnt_q == '0) begin
               stage_rst_d[0] = 1'b0;
               cnt_d          = CNT_RELOAD;
               if (STAGES == 1) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = IDX_W'(1);
                  state_d = ST_RELEASE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            if (cnt_q == '0) begin
               for (int k = 0; k < int'(STAGES); k++) begin
                  if (idx_q == IDX_W'(k)) stage_rst_d[k] = 1'b0;
               end
               cnt_d = CNT_RELOAD;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_DONE: begin
            if (soft_ack_q && !soft_req) begin
               soft_ack_d = 1'b0;
            end else if (!soft_ack_q && soft_req) begin
               stage_rst_d = '1;
               cnt_d       = CNT_RELOAD;
               idx_d       = '0;
               soft_run_d  = 1'b1;
               state_d     = ST_ASSERT;
            end
         end

         default: state_d = ST_ASSERT;
      endcase

      // Completion edge: acknowledge only sequences started by soft_req.
      if (state_d == ST_DONE && state_q != ST_DONE) begin
         soft_ack_d = soft_run_q;
         soft_run_d = 1'b0;
      end
   end

   // State and registered outputs; rst_n aborts any sequence immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ASSERT;
         cnt_q       <= CNT_RELOAD;
         idx_q       <= '0;
         stage_rst_q <= '1;
         soft_run_q  <= 1'b0;
         soft_ack_q  <= 1'b0;
         busy_q      <= 1'b1;
         all_ready_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register update from
         // pre-edge values, so statement order cannot create races.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         stage_rst_q <= stage_rst_d;
         soft_run_q  <= soft_run_d;
         soft_ack_q  <= soft_ack_d;
         busy_q      <= (state_d != ST_DONE);
         all_ready_q <= (state_d == ST_DONE);
      end
   end

   assign stage_rst = stage_rst_q;
   assign soft_ack  = soft_ack_q;
   assign busy      = busy_q;
   assign all_ready = all_ready_q;

endmodule
